// File: rtl/lagarto_csr_pmu_responder.sv
// Responder for the Lagarto CSR port: custom performance counters, event selectors and
// sticky overflow flags, with a fixed-latency IDLE/WAIT/RESP handshake on the core stall.
module lagarto_csr_pmu_responder #(
    parameter int unsigned NUM_CNT  = 8,
    parameter int unsigned EVT_W    = 16,
    parameter logic [11:0] CNT_BASE = 12'hB03,
    parameter logic [11:0] SEL_BASE = 12'h323,
    parameter logic [11:0] OVF_ADDR = 12'h7C0,
    parameter int unsigned ACC_LAT  = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [2:0]         csr_cmd_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [63:0]        csr_wdata_i,
    output logic [63:0]        csr_rdata_o,
    output logic               csr_hit_o,
    output logic               csr_stall_o,
    input  logic [EVT_W-1:0]   events_i,
    input  logic [NUM_CNT-1:0] inhibit_i
);

    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_SET   = 3'd2;
    localparam logic [2:0] CMD_CLEAR = 3'd3;
    localparam logic [2:0] CMD_READ  = 3'd4;
    localparam int unsigned WC_W = (ACC_LAT > 2) ? $clog2(ACC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [WC_W-1:0]   wait_q;
    logic [2:0]        cmd_q;
    logic [63:0]       wdata_q;
    logic              is_cnt_q, is_sel_q, is_ovf_q;
    logic [3:0]        idx_q;

    logic [63:0]       cnt_q [NUM_CNT];
    logic [4:0]        sel_q [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q;

    logic [11:0]       cnt_off, sel_off;
    logic              in_cnt, in_sel, in_ovf, cmd_valid, req_hit;
    logic [3:0]        req_idx;

    logic [63:0]       rd_val, wr_val;
    logic              commit;
    logic [31:0]       evt_ext;
    logic [NUM_CNT-1:0] inc, cnt_wr, wrap;

    // Address decode of the live request; counters take priority if ranges ever overlap.
    always_comb begin
        cnt_off   = csr_addr_i - CNT_BASE;
        sel_off   = csr_addr_i - SEL_BASE;
        in_cnt    = cnt_off < 12'(NUM_CNT);
        in_sel    = !in_cnt && (sel_off < 12'(NUM_CNT));
        in_ovf    = !in_cnt && !in_sel && (csr_addr_i == OVF_ADDR);
        req_idx   = in_cnt ? cnt_off[3:0] : sel_off[3:0];
        cmd_valid = (csr_cmd_i >= CMD_WRITE) && (csr_cmd_i <= CMD_READ);
        req_hit   = cmd_valid && (in_cnt || in_sel || in_ovf);
    end

    assign csr_hit_o   = req_hit;
    assign csr_stall_o = ((state_q == IDLE) && req_hit) || (state_q == WAIT);

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (is_cnt_q && (idx_q == 4'(i))) rd_val = cnt_q[i];
            if (is_sel_q && (idx_q == 4'(i))) rd_val = {59'b0, sel_q[i]};
        end
        if (is_ovf_q) rd_val = 64'(ovf_q);
    end

    always_comb begin
        case (cmd_q)
            CMD_WRITE: wr_val = wdata_q;
            CMD_SET:   wr_val = rd_val | wdata_q;
            CMD_CLEAR: wr_val = rd_val & ~wdata_q;
            default:   wr_val = rd_val;
        endcase
    end

    assign commit      = (state_q == RESP) && (cmd_q != CMD_READ);
    assign csr_rdata_o = (state_q == RESP) ? rd_val : '0;

    // Bit 0 of the extended vector stays 0 so selector 0 and selectors above EVT_W never count.
    always_comb begin
        evt_ext            = '0;
        evt_ext[EVT_W:1]   = events_i;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            inc[i]    = evt_ext[sel_q[i]] && !inhibit_i[i];
            cnt_wr[i] = commit && is_cnt_q && (idx_q == 4'(i));
            wrap[i]   = inc[i] && !cnt_wr[i] && (&cnt_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            cmd_q    <= '0;
            wdata_q  <= '0;
            is_cnt_q <= 1'b0;
            is_sel_q <= 1'b0;
            is_ovf_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hit) begin
                        cmd_q    <= csr_cmd_i;
                        wdata_q  <= csr_wdata_i;
                        is_cnt_q <= in_cnt;
                        is_sel_q <= in_sel;
                        is_ovf_q <= in_ovf;
                        idx_q    <= req_idx;
                        if (ACC_LAT > 1) begin
                            state_q <= WAIT;
                            wait_q  <= WC_W'(ACC_LAT - 2);
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (wait_q == '0) state_q <= RESP;
                    else              wait_q  <= wait_q - WC_W'(1);
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A commit beats a same-cycle increment; a wrap beats a same-cycle write of the flags.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (cnt_wr[i])   cnt_q[i] <= wr_val;
                else if (inc[i]) cnt_q[i] <= cnt_q[i] + 64'd1;
                if (commit && is_sel_q && (idx_q == 4'(i))) sel_q[i] <= wr_val[4:0];
            end
            ovf_q <= ((commit && is_ovf_q) ? wr_val[NUM_CNT-1:0] : ovf_q) | wrap;
        end
    end

endmodule

// File: tb/tb_lagarto_csr_pmu_responder.sv
// Scoreboard bench for lagarto_csr_pmu_responder: a cycle model predicts read data at
// request time, the prediction is queued and popped when the access reaches its response.
module tb_lagarto_csr_pmu_responder;

    localparam int unsigned NUM = 8;
    localparam int unsigned EW  = 16;
    localparam int unsigned ACC = 2;
    localparam logic [11:0] CB  = 12'hB03;
    localparam logic [11:0] SB  = 12'h323;
    localparam logic [11:0] OA  = 12'h7C0;
    localparam logic [2:0] C_NONE = 3'd0, C_WRITE = 3'd1, C_SET = 3'd2, C_CLEAR = 3'd3, C_READ = 3'd4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [2:0]     cmd;
    logic [11:0]    addr;
    logic [63:0]    wdata;
    logic [63:0]    rdata;
    logic           hit, stall;
    logic [EW-1:0]  events;
    logic [NUM-1:0] inhibit;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    logic [63:0]    m_cnt [NUM];
    logic [4:0]     m_sel [NUM];
    logic [NUM-1:0] m_ovf;

    always #5 clk = ~clk;

    lagarto_csr_pmu_responder #(
        .NUM_CNT(NUM), .EVT_W(EW), .CNT_BASE(CB), .SEL_BASE(SB), .OVF_ADDR(OA), .ACC_LAT(ACC)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .csr_cmd_i(cmd), .csr_addr_i(addr), .csr_wdata_i(wdata),
        .csr_rdata_o(rdata), .csr_hit_o(hit), .csr_stall_o(stall),
        .events_i(events), .inhibit_i(inhibit)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        int co, so;
        co = int'(a) - int'(CB);
        so = int'(a) - int'(SB);
        if (co >= 0 && co < int'(NUM)) return m_cnt[co];
        if (so >= 0 && so < int'(NUM)) return {59'b0, m_sel[so]};
        if (a == OA) return 64'(m_ovf);
        return 64'd0;
    endfunction

    // One clock edge of the reference model, using the inputs currently applied.
    task automatic m_step(input bit cm, input logic [2:0] c, input logic [11:0] a, input logic [63:0] wd);
        logic [63:0] old, nw;
        logic [NUM-1:0] n_ovf;
        int ci, si, co, so;
        bit en;
        if (!rstn) begin
            for (int i = 0; i < int'(NUM); i++) begin m_cnt[i] = '0; m_sel[i] = '0; end
            m_ovf = '0;
            return;
        end
        old = m_read(a);
        nw  = old;
        ci = -1; si = -1;
        co = int'(a) - int'(CB);
        so = int'(a) - int'(SB);
        if (cm) begin
            if (c == C_WRITE) nw = wd;
            if (c == C_SET)   nw = old | wd;
            if (c == C_CLEAR) nw = old & ~wd;
        end
        if (cm && c != C_READ) begin
            if (co >= 0 && co < int'(NUM)) ci = co;
            else if (so >= 0 && so < int'(NUM)) si = so;
        end
        n_ovf = (cm && c != C_READ && ci < 0 && si < 0 && a == OA) ? nw[NUM-1:0] : m_ovf;
        for (int i = 0; i < int'(NUM); i++) begin
            en = (m_sel[i] >= 5'd1) && (int'(m_sel[i]) <= int'(EW)) && !inhibit[i];
            if (en) en = events[int'(m_sel[i]) - 1];
            if (i == ci) m_cnt[i] = nw;
            else if (en) begin
                if (m_cnt[i] == '1) n_ovf[i] = 1'b1;
                m_cnt[i] = m_cnt[i] + 64'd1;
            end
        end
        if (si >= 0) m_sel[si] = nw[4:0];
        m_ovf = n_ovf;
    endtask

    task automatic cyc(input bit cm, input logic [2:0] c, input logic [11:0] a, input logic [63:0] wd);
        @(posedge clk);
        m_step(cm, c, a, wd);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, C_NONE, 12'h0, 64'h0);
    endtask

    // Response value: target as it will stand after ACC edges of counting with held inputs.
    task automatic predict_push(input logic [11:0] a);
        logic [63:0]    s_cnt [NUM];
        logic [4:0]     s_sel [NUM];
        logic [NUM-1:0] s_ovf;
        s_cnt = m_cnt; s_sel = m_sel; s_ovf = m_ovf;
        for (int i = 0; i < int'(ACC); i++) m_step(1'b0, C_NONE, 12'h0, 64'h0);
        exp_q.push_back(m_read(a));
        m_cnt = s_cnt; m_sel = s_sel; m_ovf = s_ovf;
    endtask

    task automatic access(input logic [2:0] c, input logic [11:0] a, input logic [63:0] wd, input string tag);
        int n;
        logic [63:0] e;
        cmd = c; addr = a; wdata = wd;
        predict_push(a);
        @(negedge clk);
        check_val({tag, "_hit"}, 64'(hit), 64'd1);
        check_val({tag, "_stall0"}, 64'(stall), 64'd1);
        cyc(1'b0, c, a, wd);
        n = 1;
        while (n < 16) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            cyc(1'b0, c, a, wd);
        end
        check_val({tag, "_lat"}, 64'(n), 64'(ACC));
        e = exp_q.pop_front();
        check_val({tag, "_rdata"}, rdata, e);
        cyc(1'b1, c, a, wd);
        cmd = C_NONE;
    endtask

    task automatic miss(input logic [2:0] c, input logic [11:0] a, input string tag);
        cmd = c; addr = a; wdata = '1;
        @(negedge clk);
        check_val({tag, "_hit"}, 64'(hit), 64'd0);
        check_val({tag, "_stall"}, 64'(stall), 64'd0);
        check_val({tag, "_rdata"}, rdata, 64'd0);
        cyc(1'b0, c, a, 64'h0);
        cmd = C_NONE;
    endtask

    initial begin
        rstn = 1'b0; cmd = C_NONE; addr = '0; wdata = '0; events = '0; inhibit = '0;
        for (int i = 0; i < int'(NUM); i++) begin m_cnt[i] = '0; m_sel[i] = '0; end
        m_ovf = '0;
        idle_cycles(2);
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_stall", 64'(stall), 64'd0);
        check_val("rst_rdata", rdata, 64'd0);
        check_val("rst_hit", 64'(hit), 64'd0);
        idle_cycles(1);

        access(C_READ, CB, 64'h0, "rd_cnt0");
        miss(C_READ, 12'h300, "miss300");
        miss(C_READ, CB + 12'(NUM), "miss_past_end");
        miss(3'd5, CB, "cmd5");

        access(C_WRITE, SB + 12'd1, 64'd3, "wr_sel1");
        events = 16'h0004;
        idle_cycles(10);
        access(C_READ, CB + 12'd1, 64'h0, "rd_cnt1");
        events = '0;
        access(C_READ, SB + 12'd1, 64'h0, "rd_sel1");
        access(C_WRITE, CB + 12'd1, 64'h0, "clr_cnt1");
        inhibit = 8'h02;
        events = 16'h0004;
        idle_cycles(10);
        access(C_READ, CB + 12'd1, 64'h0, "rd_cnt1_inh");
        events = '0;
        inhibit = '0;

        access(C_WRITE, SB, 64'd1, "wr_sel0");
        access(C_WRITE, CB, 64'hFFFF_FFFF_FFFF_FFFE, "wr_cnt0_max");
        events = 16'h0001;
        idle_cycles(2);
        events = '0;
        access(C_READ, CB, 64'h0, "rd_cnt0_wrap");
        access(C_READ, OA, 64'h0, "rd_ovf_set");
        access(C_CLEAR, OA, 64'd1, "clr_ovf");
        access(C_READ, OA, 64'h0, "rd_ovf_clr");

        access(C_WRITE, CB + 12'd2, 64'h0F, "wr_cnt2");
        access(C_SET, CB + 12'd2, 64'hF0, "set_cnt2");
        access(C_READ, CB + 12'd2, 64'h0, "rd_cnt2_ff");
        access(C_CLEAR, CB + 12'd2, 64'h0F, "clr_cnt2");
        access(C_READ, CB + 12'd2, 64'h0, "rd_cnt2_f0");
        access(C_WRITE, SB + 12'd2, '1, "wr_sel2_ones");
        access(C_READ, SB + 12'd2, 64'h0, "rd_sel2_mask");
        access(C_WRITE, SB + 12'd2, 64'h0, "wr_sel2_off");

        access(C_WRITE, SB + 12'd3, 64'd5, "wr_sel3");
        events = 16'h0010;
        idle_cycles(3);
        access(C_WRITE, CB + 12'd3, 64'h55, "wr_cnt3_coll");
        access(C_READ, CB + 12'd3, 64'h0, "rd_cnt3_coll");
        events = '0;

        access(C_WRITE, SB + 12'd4, 64'd17, "wr_sel4_big");
        access(C_WRITE, SB + 12'd7, 64'd16, "wr_sel7_top");
        events = '1;
        idle_cycles(4);
        events = '0;
        access(C_READ, CB + 12'd4, 64'h0, "rd_cnt4_off");
        access(C_READ, CB + 12'd7, 64'h0, "rd_cnt7_top");

        cmd = C_WRITE; addr = CB; wdata = 64'h99;
        @(negedge clk);
        check_val("abort_stall_t", 64'(stall), 64'd1);
        cyc(1'b0, C_WRITE, CB, 64'h99);
        rstn = 1'b0;
        @(negedge clk);
        check_val("abort_stall_wait", 64'(stall), 64'd1);
        cyc(1'b0, C_WRITE, CB, 64'h99);
        rstn = 1'b1;
        cmd = C_NONE;
        @(negedge clk);
        check_val("abort_idle_stall", 64'(stall), 64'd0);
        check_val("abort_idle_rdata", rdata, 64'd0);
        idle_cycles(1);
        access(C_READ, CB, 64'h0, "rd_cnt0_abort");

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
